// File: rtl/neuron_feeder.sv
// rtl/neuron_feeder.sv - feeds one input vector through M stored weight sets and reports the argmax neuron
module neuron_feeder #(
  parameter int N      = 10,
  parameter int DW     = 8,
  parameter int DW_VEC = N * DW,
  parameter int M      = 10,
  parameter int TMO    = 255,
  localparam int AW    = (M > 1) ? $clog2(M) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_we,
  input  logic [AW-1:0]     w_addr,
  input  logic [DW_VEC-1:0] w_data,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DW_VEC-1:0] req_vec,
  input  logic              req_shift,
  output logic              nrn_start,
  output logic              nrn_shift_en,
  output logic [DW_VEC-1:0] nrn_in_vec,
  output logic [DW_VEC-1:0] nrn_w_vec,
  input  logic [7:0]        nrn_out,
  input  logic              nrn_ready,
  output logic              res_valid,
  input  logic              res_ack,
  output logic [AW-1:0]     res_class,
  output logic [7:0]        res_score,
  output logic              res_err
);

  localparam int WW = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [AW:0]   MLIM = (AW + 1)'(M);
  localparam logic [AW-1:0] LAST = AW'(M - 1);
  localparam logic [WW-1:0] TLIM = WW'(TMO - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, GUARD, WAIT, DONE} state_t;

  state_t            state, state_nx;
  logic [AW-1:0]     idx;
  logic [WW-1:0]     wdog;
  logic [7:0]        maxv;
  logic [AW-1:0]     cls;
  logic              err;
  logic              shift;
  logic [DW_VEC-1:0] in_vec;
  logic [DW_VEC-1:0] w_hold;
  logic [DW_VEC-1:0] wmem [M];
  logic              last, sample, take, tmo_hit;

  assign last    = (idx == LAST);
  assign sample  = (state == WAIT) && nrn_ready;
  // first sample always wins so an all-zero result still reports class 0
  assign take    = sample && ((idx == '0) || (nrn_out > maxv));
  assign tmo_hit = (state == WAIT) && !nrn_ready && (wdog == TLIM);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    nrn_start = 1'b0;
    res_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = ISSUE;
      end
      ISSUE: begin
        nrn_start = 1'b1;
        state_nx  = GUARD;
      end
      GUARD: state_nx = WAIT;
      WAIT: begin
        if (sample)       state_nx = last ? DONE : ISSUE;
        else if (tmo_hit) state_nx = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ack) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx    <= '0;
      wdog   <= '0;
      maxv   <= '0;
      cls    <= '0;
      err    <= 1'b0;
      shift  <= 1'b0;
      in_vec <= '0;
      w_hold <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          in_vec <= req_vec;
          shift  <= req_shift;
          idx    <= '0;
          maxv   <= '0;
          cls    <= '0;
          err    <= 1'b0;
        end
        ISSUE: w_hold <= wmem[idx];
        GUARD: wdog <= '0;
        WAIT: begin
          if (nrn_ready) begin
            if (take) begin
              maxv <= nrn_out;
              cls  <= idx;
            end
            if (!last) idx <= idx + 1'b1;
          end else if (tmo_hit) begin
            err <= 1'b1;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // weights only change between requests so a running request sees a stable set
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < M; i++) wmem[i] <= '0;
    end else if (w_we && (state == IDLE) && ({1'b0, w_addr} < MLIM)) begin
      wmem[w_addr] <= w_data;
    end
  end

  assign nrn_w_vec    = (state == ISSUE) ? wmem[idx] : w_hold;
  assign nrn_in_vec   = in_vec;
  assign nrn_shift_en = shift;
  assign res_class    = cls;
  assign res_score    = maxv;
  assign res_err      = err;

endmodule

// File: tb/tb_neuron_feeder.sv
// tb/tb_neuron_feeder.sv - randomized self-checking bench for neuron_feeder
module tb_neuron_feeder;
  localparam int N = 10, DW = 8, DV = N * DW, M = 10, TMO = 255, AW = 4;

  logic clk = 1'b0, rst = 1'b0;
  logic w_we = 1'b0, req_valid = 1'b0, req_shift = 1'b0, res_ack = 1'b0;
  logic [AW-1:0] w_addr = '0;
  logic [DV-1:0] w_data = '0, req_vec = '0;
  logic req_ready, nrn_start, nrn_shift_en, res_valid, res_err;
  logic [DV-1:0] nrn_in_vec, nrn_w_vec;
  logic [7:0] nrn_out, res_score;
  logic nrn_ready;
  logic [AW-1:0] res_class;

  int total = 0, bad = 0;
  int dly [M];
  logic [7:0] val [M];
  logic [DV-1:0] mem_m [M];
  logic [DV-1:0] wobs [64], iobs [64];
  logic sobs [64];
  int scnt = 0;

  neuron_feeder #(.N(N), .DW(DW), .M(M), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .req_valid(req_valid), .req_ready(req_ready), .req_vec(req_vec), .req_shift(req_shift),
    .nrn_start(nrn_start), .nrn_shift_en(nrn_shift_en), .nrn_in_vec(nrn_in_vec),
    .nrn_w_vec(nrn_w_vec), .nrn_out(nrn_out), .nrn_ready(nrn_ready),
    .res_valid(res_valid), .res_ack(res_ack), .res_class(res_class),
    .res_score(res_score), .res_err(res_err)
  );

  always #5 clk = ~clk;

  // neuron model: ready is a level that stays high until the next start; junk output during GUARD
  initial begin
    int phase, cur;
    phase = -1; cur = 0;
    nrn_ready = 1'b0; nrn_out = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst) begin
        phase = -1; nrn_ready = 1'b0;
      end else if (nrn_start) begin
        cur = scnt;
        if (scnt < 64) begin
          wobs[scnt] = nrn_w_vec; iobs[scnt] = nrn_in_vec; sobs[scnt] = nrn_shift_en;
        end
        scnt++;
        phase = 0;
      end else if (phase >= 0) begin
        phase++;
        if (phase == 1) nrn_out = 8'hFF;
        else if (cur < M && dly[cur] >= 0 && phase == dly[cur] + 2) begin
          nrn_ready = 1'b1; nrn_out = val[cur]; phase = -1;
        end else nrn_ready = 1'b0;
      end
    end
  end

  function automatic logic [DV-1:0] rvec();
    return {16'($urandom), $urandom, $urandom};
  endfunction

  // best = largest value among the first n results, lowest index on ties
  function automatic void ref_best(input int n, output int c, output int s);
    s = 0; c = 0;
    for (int i = 0; i < n; i++) if (int'(val[i]) > s) s = int'(val[i]);
    for (int i = n - 1; i >= 0; i--) if (int'(val[i]) == s) c = i;
  endfunction

  function automatic int ref_lat();
    int acc = 0;
    for (int i = 0; i < M; i++) begin
      if (dly[i] < 0) return acc + 2 + TMO + 1;
      acc += 3 + dly[i];
    end
    return acc + 1;
  endfunction

  function automatic int ref_done();
    for (int i = 0; i < M; i++) if (dly[i] < 0) return i;
    return M;
  endfunction

  function automatic int start_errs(int n, logic [DV-1:0] v, logic s);
    int e = 0;
    for (int j = 0; j < n; j++)
      if (wobs[j] !== mem_m[j] || iobs[j] !== v || sobs[j] !== s) e++;
    return e;
  endfunction

  task automatic load(input int a, input logic [DV-1:0] d);
    w_we = 1'b1; w_addr = AW'(a); w_data = d;
    @(negedge clk);
    w_we = 1'b0;
    if (a < M) mem_m[a] = d;
  endtask

  task automatic do_request(input logic [DV-1:0] v, input logic s, input bit wr, input int wa,
                            input logic [DV-1:0] wd, output int lat, output bit to);
    scnt = 0; req_vec = v; req_shift = s; req_valid = 1'b1; lat = 0; to = 1'b0;
    if (wr) begin
      w_we = 1'b1; w_addr = AW'(wa); w_data = wd;
      if (wa < M) mem_m[wa] = wd;
    end
    do begin
      @(negedge clk); lat++; req_valid = 1'b0; w_we = 1'b0;
    end while (!res_valid && lat < 4000);
    if (!res_valid) to = 1'b1;
  endtask

  task automatic ack();
    res_ack = 1'b1; @(negedge clk); res_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    total++; if ({res_valid, nrn_start, nrn_shift_en, res_err} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {res_valid, nrn_start, nrn_shift_en, res_err}); end
    total++; if (nrn_w_vec !== '0 || nrn_in_vec !== '0) begin bad++; $display("FAIL reset_vecs got=%h/%h exp=0", nrn_w_vec, nrn_in_vec); end
    total++; if (res_class !== '0 || res_score !== 8'h00) begin bad++; $display("FAIL reset_result got=%0d/%0d exp=0/0", res_class, res_score); end
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < M; i++) mem_m[i] = '0;
  endtask

  task automatic test_basic();
    int lat, c, s; bit to; logic [DV-1:0] v;
    for (int i = 0; i < M; i++) load(i, rvec());
    load(12, rvec());
    val[0] = 8'd10; val[1] = 8'd40; val[2] = 8'd7;
    for (int i = 3; i < M; i++) val[i] = 8'($urandom_range(0, 39));
    for (int i = 0; i < M; i++) dly[i] = $urandom_range(0, 3);
    v = rvec();
    do_request(v, 1'b1, 1'b0, 0, '0, lat, to);
    ref_best(M, c, s);
    total++; if (to) begin bad++; $display("FAIL basic_timeout got=no res_valid exp=res_valid"); end
    total++; if (res_class !== AW'(1) || c != 1) begin bad++; $display("FAIL basic_class got=%0d exp=1", res_class); end
    total++; if (res_score !== 8'd40 || s != 40) begin bad++; $display("FAIL basic_score got=%0d exp=40", res_score); end
    total++; if (res_err !== 1'b0) begin bad++; $display("FAIL basic_err got=%b exp=0", res_err); end
    total++; if (scnt != M) begin bad++; $display("FAIL basic_starts got=%0d exp=%0d", scnt, M); end
    total++; if (lat != ref_lat()) begin bad++; $display("FAIL basic_latency got=%0d exp=%0d", lat, ref_lat()); end
    total++; if (start_errs(M, v, 1'b1) != 0) begin bad++; $display("FAIL basic_vectors got=%0d bad starts exp=0", start_errs(M, v, 1'b1)); end
    ack();
  endtask

  task automatic test_tie();
    int lat; bit to;
    for (int i = 0; i < M; i++) begin val[i] = 8'h55; dly[i] = $urandom_range(0, 2); end
    do_request(rvec(), 1'b0, 1'b0, 0, '0, lat, to);
    total++; if (res_class !== AW'(0)) begin bad++; $display("FAIL tie_class got=%0d exp=0", res_class); end
    total++; if (res_score !== 8'h55 || to) begin bad++; $display("FAIL tie_score got=%h exp=55", res_score); end
    ack();
  endtask

  task automatic test_random();
    int lat, c, s, wa; bit to; logic s_in; logic [DV-1:0] v, wd;
    for (int it = 0; it < 5; it++) begin
      for (int i = 0; i < M; i++) begin val[i] = 8'($urandom_range(0, 7)); dly[i] = $urandom_range(0, 4); end
      if (it == 4) for (int i = 0; i < M; i++) val[i] = 8'($urandom_range(200, 255));
      v = rvec(); wd = rvec(); s_in = 1'($urandom); wa = $urandom_range(0, M - 1);
      do_request(v, s_in, 1'b1, wa, wd, lat, to);
      ref_best(M, c, s);
      total++; if (res_class !== AW'(c) || to) begin bad++; $display("FAIL rand%0d_class got=%0d exp=%0d", it, res_class, c); end
      total++; if (res_score !== 8'(s)) begin bad++; $display("FAIL rand%0d_score got=%0d exp=%0d", it, res_score, s); end
      total++; if (lat != ref_lat()) begin bad++; $display("FAIL rand%0d_latency got=%0d exp=%0d", it, lat, ref_lat()); end
      total++; if (start_errs(M, v, s_in) != 0 || scnt != M) begin bad++; $display("FAIL rand%0d_vectors got=%0d bad starts of %0d exp=0 of %0d", it, start_errs(M, v, s_in), scnt, M); end
      ack();
    end
  endtask

  task automatic test_timeout();
    int lat, c, s; bit to; logic [DV-1:0] v;
    for (int i = 0; i < M; i++) begin val[i] = 8'($urandom_range(0, 255)); dly[i] = $urandom_range(0, 2); end
    dly[3] = -1;
    v = rvec();
    do_request(v, 1'b0, 1'b0, 0, '0, lat, to);
    ref_best(ref_done(), c, s);
    total++; if (res_valid !== 1'b1 || res_err !== 1'b1) begin bad++; $display("FAIL tmo_flags got=%b%b exp=11", res_valid, res_err); end
    total++; if (res_class !== AW'(c) || res_score !== 8'(s)) begin bad++; $display("FAIL tmo_best got=%0d/%0d exp=%0d/%0d", res_class, res_score, c, s); end
    total++; if (lat != ref_lat()) begin bad++; $display("FAIL tmo_latency got=%0d exp=%0d", lat, ref_lat()); end
    total++; if (scnt != 4 || start_errs(4, v, 1'b0) != 0) begin bad++; $display("FAIL tmo_starts got=%0d exp=4", scnt); end
    ack();
  endtask

  task automatic test_write_busy();
    int lat, n; bit to; logic [DV-1:0] v, old5;
    for (int i = 0; i < M; i++) begin val[i] = 8'($urandom_range(0, 255)); dly[i] = 2; end
    old5 = mem_m[5]; v = rvec(); scnt = 0;
    req_vec = v; req_shift = 1'b0; req_valid = 1'b1;
    @(negedge clk); req_valid = 1'b0;
    repeat (7) @(negedge clk);
    w_we = 1'b1; w_addr = AW'(5); w_data = ~old5;
    @(negedge clk); w_we = 1'b0;
    n = 0;
    while (!res_valid && n < 2000) begin @(negedge clk); n++; end
    total++; if (!res_valid || wobs[5] !== old5) begin bad++; $display("FAIL busy_write_same got=%h exp=%h", wobs[5], old5); end
    ack();
    do_request(v, 1'b0, 1'b0, 0, '0, lat, to);
    total++; if (wobs[5] !== old5 || start_errs(M, v, 1'b0) != 0 || to) begin bad++; $display("FAIL busy_write_next got=%h exp=%h", wobs[5], old5); end
    ack();
  endtask

  task automatic test_ack_hold();
    int lat, c, s, st; bit to;
    for (int i = 0; i < M; i++) begin val[i] = 8'($urandom_range(0, 255)); dly[i] = $urandom_range(0, 1); end
    do_request(rvec(), 1'b1, 1'b0, 0, '0, lat, to);
    ref_best(M, c, s);
    st = scnt;
    for (int i = 0; i < 20; i++) begin
      req_valid = 1'b1; res_ack = 1'b0;
      @(negedge clk);
      total++;
      if (res_valid !== 1'b1 || req_ready !== 1'b0 || res_class !== AW'(c) || res_score !== 8'(s) || res_err !== 1'b0)
        begin bad++; $display("FAIL hold_%0d got=v%b r%b c%0d s%0d e%b exp=v1 r0 c%0d s%0d e0", i, res_valid, req_ready, res_class, res_score, res_err, c, s); end
    end
    req_valid = 1'b0;
    ack();
    total++; if (req_ready !== 1'b1 || res_valid !== 1'b0 || scnt != st) begin bad++; $display("FAIL ack_idle got=r%b v%b starts=%0d exp=r1 v0 starts=%0d", req_ready, res_valid, scnt, st); end
  endtask

  task automatic test_reset_mid();
    int n, st, lat; bit to; logic [DV-1:0] v;
    for (int i = 0; i < M; i++) begin val[i] = 8'($urandom_range(1, 255)); dly[i] = 1; end
    dly[4] = 8; v = rvec(); scnt = 0;
    req_vec = v; req_shift = 1'b1; req_valid = 1'b1;
    @(negedge clk); req_valid = 1'b0;
    n = 0;
    while (scnt < 5 && n < 500) begin @(negedge clk); n++; end
    total++; if (scnt < 5) begin bad++; $display("FAIL rmid_reach got=%0d starts exp=5", scnt); end
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    total++; if (req_ready !== 1'b1 || {res_valid, nrn_start, nrn_shift_en, res_err} !== 4'b0) begin bad++; $display("FAIL rmid_flags got=r%b %b exp=r1 0000", req_ready, {res_valid, nrn_start, nrn_shift_en, res_err}); end
    total++; if (nrn_w_vec !== '0 || nrn_in_vec !== '0 || res_class !== '0 || res_score !== 8'h00) begin bad++; $display("FAIL rmid_zero got=%h %h %0d %0d exp=0", nrn_w_vec, nrn_in_vec, res_class, res_score); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < M; i++) mem_m[i] = '0;
    st = scnt;
    repeat (20) @(negedge clk);
    total++; if (scnt != st) begin bad++; $display("FAIL rmid_nostart got=%0d exp=%0d", scnt, st); end
    for (int i = 0; i < M; i++) dly[i] = 0;
    do_request(v, 1'b0, 1'b0, 0, '0, lat, to);
    total++; if (start_errs(M, v, 1'b0) != 0 || to) begin bad++; $display("FAIL rmid_memclear got=%0d bad starts exp=0", start_errs(M, v, 1'b0)); end
    ack();
  endtask

  initial begin
    #3000000;
    $display("FAIL global_timeout got=hang exp=finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < M; i++) begin dly[i] = 0; val[i] = 8'h00; mem_m[i] = '0; end
    test_reset();
    test_basic();
    test_tie();
    test_random();
    test_timeout();
    test_write_busy();
    test_ack_hold();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/neuron_feeder.md
NEURON_FEEDER -- requirements
Module: neuron_feeder

Interface
REQ-001 Parameter N, default 10, SHALL be the elements per input/weight vector.
REQ-002 Parameter DW, default 8, SHALL be the element width in bits.
REQ-003 Parameter DW_VEC, default N*DW, SHALL be the packed vector width.
REQ-004 Parameter M, default 10, SHALL be the number of weight sets (neurons); AW = ceil(log2(M)), minimum 1.
REQ-005 Parameter TMO, default 255, SHALL be the WAIT-state watchdog limit in cycles.
REQ-006 clk  in  1  sole clock; all state changes on rising edge.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 w_we  in  1  weight-memory write strobe.
REQ-009 w_addr  in  AW  weight-set index.
REQ-010 w_data  in  DW_VEC  weight vector to store.
REQ-011 req_valid  in  1  classification request.
REQ-012 req_ready  out  1  high only in IDLE.
REQ-013 req_vec  in  DW_VEC  input vector; captured on handshake.
REQ-014 req_shift  in  1  shift mode; captured on handshake.
REQ-015 nrn_start  out  1  one-cycle neuron start pulse.
REQ-016 nrn_shift_en  out  1  captured req_shift, stable for the whole request.
REQ-017 nrn_in_vec  out  DW_VEC  captured req_vec.
REQ-018 nrn_w_vec  out  DW_VEC  weight set for current index.
REQ-019 nrn_out  in  8  neuron result.
REQ-020 nrn_ready  in  1  neuron-done level.
REQ-021 res_valid  out  1  result available.
REQ-022 res_ack  in  1  result consumed.
REQ-023 res_class  out  AW  index of maximum neuron output.
REQ-024 res_score  out  8  maximum neuron output value, unsigned.
REQ-025 res_err  out  1  request aborted by watchdog.

Function
REQ-026 States SHALL be IDLE, ISSUE, GUARD, WAIT, DONE.
REQ-027 IDLE: req_valid=1 -> capture req_vec/req_shift, idx=0, max=0, cls=0, err=0, go to ISSUE.
REQ-028 ISSUE: nrn_start=1 for exactly this cycle, nrn_w_vec=wmem[idx] (held until next ISSUE), go to GUARD.
REQ-029 GUARD: nrn_ready ignored for this one cycle, then go to WAIT with watchdog cleared.
REQ-030 WAIT: nrn_ready=1 -> sample nrn_out that cycle; if idx==0 or nrn_out > max (strict, unsigned), max=nrn_out and cls=idx; ties keep lower index.
REQ-031 WAIT after sampling: idx==M-1 -> DONE, else idx+1 -> ISSUE; start-to-start minimum spacing therefore 3 cycles.
REQ-032 WAIT: watchdog increments each cycle nrn_ready=0; reaching TMO -> err=1, go to DONE with res_class/res_score holding best-so-far.
REQ-033 DONE: res_valid=1; res_class, res_score, res_err stable until res_ack=1, then go to IDLE next cycle.
REQ-034 res_ack outside DONE SHALL be ignored; req_valid outside IDLE SHALL not be accepted.
REQ-035 Weight write SHALL take effect next cycle only when state is IDLE; w_we in any other state is dropped silently.
REQ-036 w_addr >= M SHALL be ignored.
REQ-037 Simultaneous w_we and req_valid in IDLE: the write completes, and the request uses the updated data.
REQ-038 Request end-to-end latency with a neuron ready k cycles after GUARD SHALL be M*(3+k)+1 cycles from handshake to res_valid.

Reset
REQ-039 rst low SHALL immediately force IDLE, idx=0, watchdog=0, max=0, cls=0; all outputs 0 except req_ready=1.
REQ-040 Reset SHALL clear weight memory to zero; a reset mid-request abandons the request and issues no further nrn_start.

Verification
REQ-041 Bench SHALL cover the following scenarios:
- Load M=10 sets; neuron model returns 10,40,7,...; request -> 10 start pulses, res_class=1, res_score=40, res_err=0.
- All outputs equal 0x55 -> res_class=0, res_score=0x55 (tie rule).
- Model never asserts ready on idx=3, TMO=255 -> 256th WAIT cycle yields res_valid=1, res_err=1, with best of idx 0..2.
- w_we during WAIT to idx 5 -> memory unchanged; next request drives old set 5.
- rst low during WAIT of idx 4 -> outputs zeroed same cycle, req_ready=1, no further nrn_start.
- res_ack held low 20 cycles -> results stable, req_ready=0 throughout; ack -> IDLE next cycle.
